host_link_sequencer: RTL and testbench
======================================

HOST_LINK_SEQUENCER -- requirements
Module: host_link_sequencer

Interface
REQ-001 Parameter N_IN, 4: number of 32-bit operand words loaded from host (1..8).
REQ-002 Parameter N_OUT, 1: number of 32-bit result words returned to host (1..8); N_IN+N_OUT SHALL be <= 16.
REQ-003 Parameter GAP_TIMEOUT, 5_000_000: max i_Clk cycles between received bytes inside a frame.
REQ-004 Parameter PROC_TIMEOUT, 50_000_000: max cycles waiting for processor busy to rise, then to fall.
REQ-005 i_Clk  in  1  system clock, all logic on rising edge.
REQ-006 i_Rst  in  1  reset, asynchronous, active-high.
REQ-007 i_rx_data  in  8  byte from UART receiver, valid with i_rx_end.
REQ-008 i_rx_end  in  1  one-cycle pulse, new received byte.
REQ-009 i_txd_busy  in  1  UART transmitter busy.
REQ-010 o_tx_data  out  8  byte to transmit, stable from o_send_to_computer until i_txd_busy falls.
REQ-011 o_send_to_computer  out  1  one-cycle transmit request.
REQ-012 o_mem_index  out  4  processor data-memory word index.
REQ-013 o_rx_number  out  32  word to write at o_mem_index.
REQ-014 o_mem_we  out  1  one-cycle write strobe.
REQ-015 i_tx_number  in  32  word read at o_mem_index, valid one cycle after index changes.
REQ-016 o_proc_start  out  1  one-cycle processor start pulse.
REQ-017 i_proc_busy  in  1  processor running.
REQ-018 o_state  out  3  current state encoding, debug.
REQ-019 o_error  out  1  sticky error flag, cleared by next valid sync byte or reset.

Function
REQ-020 States SHALL be IDLE, RX_WORD, START, WAIT_RISE, WAIT_FALL, TX_LOAD, TX_SEND, TX_WAIT.
REQ-021 IDLE: on i_rx_end with byte 0xA5 -> RX_WORD, word count 0, byte count 0, o_error cleared; other bytes ignored.
REQ-022 RX_WORD: bytes assembled little-endian; on 4th byte, o_rx_number=word, o_mem_index=word count, o_mem_we pulsed one cycle, word count +1.
REQ-023 After N_IN-th word write -> START; further i_rx_end ignored until IDLE.
REQ-024 Gap counter reset on each i_rx_end in RX_WORD; reaching GAP_TIMEOUT -> IDLE, o_error=1, no partial word written.
REQ-025 START: o_proc_start pulsed exactly one cycle -> WAIT_RISE.
REQ-026 WAIT_RISE: i_proc_busy=1 -> WAIT_FALL; PROC_TIMEOUT cycles without rise -> IDLE, o_error=1.
REQ-027 WAIT_FALL: i_proc_busy=0 -> TX_LOAD with o_mem_index=N_IN; PROC_TIMEOUT cycles still busy -> IDLE, o_error=1.
REQ-028 TX_LOAD: wait one cycle, latch i_tx_number into shift register, byte count 0 -> TX_SEND.
REQ-029 TX_SEND: when i_txd_busy=0, o_tx_data=current byte (LSB first), o_send_to_computer pulsed one cycle -> TX_WAIT.
REQ-030 TX_WAIT: wait for i_txd_busy=1 then i_txd_busy=0; if busy never observed high within 4 cycles, treat byte as sent.
REQ-031 After 4th byte: if results sent < N_OUT, o_mem_index+1 -> TX_LOAD; else -> IDLE.
REQ-032 o_mem_we and o_proc_start SHALL never be high together; o_send_to_computer never high outside TX_SEND.
REQ-033 i_rx_end coincident with a timeout SHALL be served first (byte accepted, counter cleared).
REQ-034 Counters sized to parameters; no wrap inside a frame.

Reset
REQ-035 i_Rst=1 asynchronously forces IDLE, all outputs 0, counters and shift registers 0, o_error 0, at any state including mid-frame or mid-transmit.
REQ-036 After reset release, first active edge evaluates IDLE; an in-flight UART byte SHALL not be retransmitted.

Structure
REQ-037 Shared package: state enum, SYNC_BYTE=8'hA5, BYTES_PER_WORD=4.
REQ-038 One sub-module natural: seq_timeout_counter (load, clear, expire), instanced for gap and processor timeouts.

Verification
REQ-039 Sync A5, bytes 78 56 34 12 x4 -> four o_mem_we, index 0..3, data 0x12345678; one o_proc_start.
REQ-040 busy high 10 cycles, i_tx_number=0xDEADBEEF at index 4 -> TX bytes EF BE AD DE, one pulse per busy cycle, then IDLE.
REQ-041 A5 then 2 bytes then silence GAP_TIMEOUT (test value 100) -> IDLE, o_error=1, no o_mem_we.
REQ-042 Processor never asserts busy, PROC_TIMEOUT=200 -> IDLE at cycle 200, o_error=1, no TX.
REQ-043 i_Rst asserted during 2nd TX byte -> outputs 0 same cycle; new A5 frame completes normally.
REQ-044 Bytes 00 FF before A5 ignored; frame after A5 processed identically to REQ-039.

Source files
------------

// File: rtl/host_link_sequencer_pkg.sv
// Shared types and constants for the host link sequencer: FSM state encoding,
// framing constants and a counter-width helper.
package host_link_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RX_WORD   = 3'd1,
      ST_START     = 3'd2,
      ST_WAIT_RISE = 3'd3,
      ST_WAIT_FALL = 3'd4,
      ST_TX_LOAD   = 3'd5,
      ST_TX_SEND   = 3'd6,
      ST_TX_WAIT   = 3'd7
   } seq_state_t;

   localparam logic [7:0] SYNC_BYTE      = 8'hA5;
   localparam int         BYTES_PER_WORD = 4;
   // Cycles the transmitter gets to raise busy before a byte counts as sent.
   localparam int         TX_ACK_WINDOW  = 4;

   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/host_link_sequencer_timeout.sv
// Down-counting timeout: load arms it with TIMEOUT, expire flags the last
// counted cycle so the owner can act on that same edge.
module seq_timeout_counter
   import host_link_sequencer_pkg::*;
#(
   parameter int TIMEOUT = 100
) (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic load,
   input  logic clear,
   output logic expire
);

   localparam int CNT_W = cnt_width(TIMEOUT);

   logic [CNT_W-1:0] count;

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst)
         count <= '0;
      else if (load)
         count <= CNT_W'(TIMEOUT);
      else if (clear)
         count <= '0;
      else if (count != '0)
         count <= count - CNT_W'(1);
   end

   assign expire = (count == CNT_W'(1));

endmodule

// File: rtl/host_link_sequencer.sv
// Host link sequencer: receives operand words over UART, kicks the processor,
// then streams the result words back to the host LSB first.
//
// state      | meaning
// IDLE       | hunting for the sync byte
// RX_WORD    | assembling operand bytes, writing each full word
// START      | one-cycle processor start pulse
// WAIT_RISE  | waiting for processor busy to assert
// WAIT_FALL  | waiting for processor busy to drop
// TX_LOAD    | result word read latency, then latch into shift register
// TX_SEND    | request transmission of the current byte
// TX_WAIT    | waiting for the transmitter to finish the byte
module host_link_sequencer
   import host_link_sequencer_pkg::*;
#(
   parameter int N_IN         = 4,
   parameter int N_OUT        = 1,
   parameter int GAP_TIMEOUT  = 5_000_000,
   parameter int PROC_TIMEOUT = 50_000_000
) (
   input  logic        i_Clk,
   input  logic        i_Rst,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_end,
   input  logic        i_txd_busy,
   output logic [7:0]  o_tx_data,
   output logic        o_send_to_computer,
   output logic [3:0]  o_mem_index,
   output logic [31:0] o_rx_number,
   output logic        o_mem_we,
   input  logic [31:0] i_tx_number,
   output logic        o_proc_start,
   input  logic        i_proc_busy,
   output logic [2:0]  o_state,
   output logic        o_error
);

   seq_state_t  state, state_nxt;
   logic [1:0]  byte_cnt, byte_cnt_nxt;
   logic [3:0]  word_cnt, word_cnt_nxt;
   logic [3:0]  res_cnt, res_cnt_nxt;
   logic [1:0]  ack_cnt, ack_cnt_nxt;
   logic        busy_seen, busy_seen_nxt;
   logic        load_dly, load_dly_nxt;
   logic [23:0] rx_shift, rx_shift_nxt;
   logic [31:0] tx_shift, tx_shift_nxt;
   logic [3:0]  mem_index, mem_index_nxt;
   logic [31:0] rx_number, rx_number_nxt;
   logic        mem_we, mem_we_nxt;
   logic        proc_start, proc_start_nxt;
   logic        error, error_nxt;
   logic        byte_done;

   logic gap_load, gap_clear, gap_expire;
   logic proc_load, proc_clear, proc_expire;

   assign gap_clear  = (state != ST_RX_WORD);
   assign proc_clear = (state != ST_WAIT_RISE) && (state != ST_WAIT_FALL);

   seq_timeout_counter #(.TIMEOUT(GAP_TIMEOUT)) u_gap_timeout (
      .i_Clk  (i_Clk),
      .i_Rst  (i_Rst),
      .load   (gap_load),
      .clear  (gap_clear),
      .expire (gap_expire)
   );

   seq_timeout_counter #(.TIMEOUT(PROC_TIMEOUT)) u_proc_timeout (
      .i_Clk  (i_Clk),
      .i_Rst  (i_Rst),
      .load   (proc_load),
      .clear  (proc_clear),
      .expire (proc_expire)
   );

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state      <= ST_IDLE;
         byte_cnt   <= '0;
         word_cnt   <= '0;
         res_cnt    <= '0;
         ack_cnt    <= '0;
         busy_seen  <= 1'b0;
         load_dly   <= 1'b0;
         rx_shift   <= '0;
         tx_shift   <= '0;
         mem_index  <= '0;
         rx_number  <= '0;
         mem_we     <= 1'b0;
         proc_start <= 1'b0;
         error      <= 1'b0;
      end else begin
         state      <= state_nxt;
         byte_cnt   <= byte_cnt_nxt;
         word_cnt   <= word_cnt_nxt;
         res_cnt    <= res_cnt_nxt;
         ack_cnt    <= ack_cnt_nxt;
         busy_seen  <= busy_seen_nxt;
         load_dly   <= load_dly_nxt;
         rx_shift   <= rx_shift_nxt;
         tx_shift   <= tx_shift_nxt;
         mem_index  <= mem_index_nxt;
         rx_number  <= rx_number_nxt;
         mem_we     <= mem_we_nxt;
         proc_start <= proc_start_nxt;
         error      <= error_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      byte_cnt_nxt   = byte_cnt;
      word_cnt_nxt   = word_cnt;
      res_cnt_nxt    = res_cnt;
      ack_cnt_nxt    = ack_cnt;
      busy_seen_nxt  = busy_seen;
      load_dly_nxt   = load_dly;
      rx_shift_nxt   = rx_shift;
      tx_shift_nxt   = tx_shift;
      mem_index_nxt  = mem_index;
      rx_number_nxt  = rx_number;
      mem_we_nxt     = 1'b0;
      proc_start_nxt = 1'b0;
      error_nxt      = error;
      gap_load       = 1'b0;
      proc_load      = 1'b0;
      byte_done      = 1'b0;

      case (state)
         ST_IDLE: begin
            if (i_rx_end && (i_rx_data == SYNC_BYTE)) begin
               state_nxt    = ST_RX_WORD;
               word_cnt_nxt = '0;
               byte_cnt_nxt = '0;
               error_nxt    = 1'b0;
               gap_load     = 1'b1;
            end
         end

         ST_RX_WORD: begin
            // A byte landing on the timeout cycle wins over the timeout.
            if (i_rx_end) begin
               gap_load     = 1'b1;
               rx_shift_nxt = {i_rx_data, rx_shift[23:8]};
               if (byte_cnt == 2'(BYTES_PER_WORD - 1)) begin
                  byte_cnt_nxt  = '0;
                  rx_number_nxt = {i_rx_data, rx_shift};
                  mem_index_nxt = word_cnt;
                  mem_we_nxt    = 1'b1;
                  word_cnt_nxt  = word_cnt + 4'd1;
                  if (word_cnt == 4'(N_IN - 1))
                     state_nxt = ST_START;
               end else begin
                  byte_cnt_nxt = byte_cnt + 2'd1;
               end
            end else if (gap_expire) begin
               state_nxt = ST_IDLE;
               error_nxt = 1'b1;
            end
         end

         // Entered while the last word's write strobe is high, so the start
         // pulse is issued one cycle later and the two never overlap.
         ST_START: begin
            proc_start_nxt = 1'b1;
            proc_load      = 1'b1;
            state_nxt      = ST_WAIT_RISE;
         end

         ST_WAIT_RISE: begin
            if (i_proc_busy) begin
               proc_load = 1'b1;
               state_nxt = ST_WAIT_FALL;
            end else if (proc_expire) begin
               state_nxt = ST_IDLE;
               error_nxt = 1'b1;
            end
         end

         ST_WAIT_FALL: begin
            if (!i_proc_busy) begin
               state_nxt     = ST_TX_LOAD;
               mem_index_nxt = 4'(N_IN);
               res_cnt_nxt   = '0;
               load_dly_nxt  = 1'b0;
            end else if (proc_expire) begin
               state_nxt = ST_IDLE;
               error_nxt = 1'b1;
            end
         end

         ST_TX_LOAD: begin
            if (!load_dly) begin
               load_dly_nxt = 1'b1;
            end else begin
               load_dly_nxt = 1'b0;
               tx_shift_nxt = i_tx_number;
               byte_cnt_nxt = '0;
               state_nxt    = ST_TX_SEND;
            end
         end

         ST_TX_SEND: begin
            if (!i_txd_busy) begin
               busy_seen_nxt = 1'b0;
               ack_cnt_nxt   = '0;
               state_nxt     = ST_TX_WAIT;
            end
         end

         ST_TX_WAIT: begin
            if (busy_seen)
               byte_done = !i_txd_busy;
            else
               byte_done = !i_txd_busy && (ack_cnt == 2'(TX_ACK_WINDOW - 1));

            if (byte_done) begin
               tx_shift_nxt = {8'h00, tx_shift[31:8]};
               if (byte_cnt == 2'(BYTES_PER_WORD - 1)) begin
                  res_cnt_nxt = res_cnt + 4'd1;
                  if (res_cnt == 4'(N_OUT - 1)) begin
                     state_nxt = ST_IDLE;
                  end else begin
                     mem_index_nxt = mem_index + 4'd1;
                     load_dly_nxt  = 1'b0;
                     state_nxt     = ST_TX_LOAD;
                  end
               end else begin
                  byte_cnt_nxt = byte_cnt + 2'd1;
                  state_nxt    = ST_TX_SEND;
               end
            end else if (i_txd_busy) begin
               busy_seen_nxt = 1'b1;
            end else begin
               ack_cnt_nxt = ack_cnt + 2'd1;
            end
         end

         default: state_nxt = ST_IDLE;
      endcase
   end

   assign o_state            = state;
   assign o_error            = error;
   assign o_mem_index        = mem_index;
   assign o_rx_number        = rx_number;
   assign o_mem_we           = mem_we;
   assign o_proc_start       = proc_start;
   assign o_tx_data          = tx_shift[7:0];
   assign o_send_to_computer = (state == ST_TX_SEND) && !i_txd_busy;

endmodule

// File: tb/tb_host_link_sequencer.sv
// Directed bench for host_link_sequencer: transaction-level model of frames
// (expected writes and result bytes) checked by a per-cycle monitor.
module tb_host_link_sequencer;

   localparam int N_IN          = 4;
   localparam int N_OUT         = 1;
   localparam int GAP_T         = 100;
   localparam int PROC_T        = 200;
   localparam int UART_BUSY     = 3;
   localparam int PROC_BUSY_CYC = 10;

   logic        i_Clk, i_Rst;
   logic [7:0]  i_rx_data;
   logic        i_rx_end, i_txd_busy;
   logic [7:0]  o_tx_data;
   logic        o_send_to_computer;
   logic [3:0]  o_mem_index;
   logic [31:0] o_rx_number;
   logic        o_mem_we;
   logic [31:0] i_tx_number;
   logic        o_proc_start, i_proc_busy;
   logic [2:0]  o_state;
   logic        o_error;

   host_link_sequencer #(
      .N_IN(N_IN), .N_OUT(N_OUT), .GAP_TIMEOUT(GAP_T), .PROC_TIMEOUT(PROC_T)
   ) dut (
      .i_Clk(i_Clk), .i_Rst(i_Rst), .i_rx_data(i_rx_data), .i_rx_end(i_rx_end),
      .i_txd_busy(i_txd_busy), .o_tx_data(o_tx_data),
      .o_send_to_computer(o_send_to_computer), .o_mem_index(o_mem_index),
      .o_rx_number(o_rx_number), .o_mem_we(o_mem_we), .i_tx_number(i_tx_number),
      .o_proc_start(o_proc_start), .i_proc_busy(i_proc_busy),
      .o_state(o_state), .o_error(o_error)
   );

   typedef struct packed {
      logic [3:0]  idx;
      logic [31:0] data;
   } wr_t;

   int n_checks = 0;
   int n_fail   = 0;
   int n_starts = 0;
   int n_sent   = 0;
   int n_busy   = 0;

   wr_t         exp_wr[$];
   logic [7:0]  exp_tx[$];
   wr_t         wr_log[$];
   logic [7:0]  tx_log[$];
   logic [31:0] frame_words[N_IN];
   logic [31:0] res_mem[16];
   logic [3:0]  idx_q;
   logic [7:0]  last_tx;
   bit          tx_track    = 1'b0;
   bit          uart_silent = 1'b0;
   bit          proc_mode   = 1'b1;

   initial i_Clk = 1'b0;
   always #5 i_Clk = ~i_Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Result memory with one cycle of read latency.
   initial begin
      i_tx_number = '0;
      idx_q = '0;
      forever begin
         @(posedge i_Clk);
         #1;
         i_tx_number = res_mem[idx_q];
         idx_q = o_mem_index;
      end
   end

   // Processor: goes busy the cycle after start for PROC_BUSY_CYC cycles.
   initial begin
      i_proc_busy = 1'b0;
      forever begin
         @(negedge i_Clk);
         if (o_proc_start && proc_mode && !i_Rst) begin
            @(posedge i_Clk);
            #1 i_proc_busy = 1'b1;
            repeat (PROC_BUSY_CYC) @(posedge i_Clk);
            #1 i_proc_busy = 1'b0;
         end
      end
   end

   // UART transmitter: busy for UART_BUSY cycles per request unless silent.
   initial begin
      i_txd_busy = 1'b0;
      forever begin
         @(negedge i_Clk);
         if (o_send_to_computer && !i_Rst && !uart_silent) begin
            @(posedge i_Clk);
            #1 i_txd_busy = 1'b1;
            n_busy++;
            repeat (UART_BUSY) @(posedge i_Clk);
            #1 i_txd_busy = 1'b0;
         end
      end
   end

   // Compare process: every write, start and transmit request against the model.
   always @(negedge i_Clk) begin
      if (!i_Rst) begin
         if (o_mem_we) begin
            wr_log.push_back({o_mem_index, o_rx_number});
            if (exp_wr.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_write: got idx %0d data %h expected no write", o_mem_index, o_rx_number);
            end else begin
               wr_t e;
               e = exp_wr.pop_front();
               check("wr_index", o_mem_index, e.idx);
               check("wr_data", o_rx_number, e.data);
            end
         end
         if (o_proc_start) begin
            n_starts++;
            check("start_vs_we", o_mem_we, 1'b0);
         end
         if (o_send_to_computer) begin
            n_sent++;
            tx_log.push_back(o_tx_data);
            last_tx  = o_tx_data;
            tx_track = 1'b1;
            check("send_state", o_state, 3'd6);
            if (exp_tx.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_send: got byte %h expected no send", o_tx_data);
            end else begin
               check("tx_byte", o_tx_data, exp_tx.pop_front());
            end
         end else if (i_txd_busy && tx_track) begin
            check("tx_data_stable", o_tx_data, last_tx);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge i_Clk);
      #1 i_rx_data = b; i_rx_end = 1'b1;
      @(posedge i_Clk);
      #1 i_rx_end = 1'b0;
   endtask

   task automatic send_frame(input bit with_sync);
      if (with_sync) send_byte(8'hA5);
      for (int i = 0; i < N_IN; i++)
         for (int b = 0; b < 4; b++)
            send_byte(frame_words[i][8*b +: 8]);
   endtask

   // Model: every operand word written in order, result returned LSB first.
   task automatic expect_frame(input logic [31:0] result, input bit with_tx);
      for (int i = 0; i < N_IN; i++)
         exp_wr.push_back({4'(i), frame_words[i]});
      res_mem[N_IN] = result;
      if (with_tx)
         for (int b = 0; b < 4; b++)
            exp_tx.push_back(result[8*b +: 8]);
   endtask

   task automatic clear_logs();
      n_starts = 0; n_sent = 0; n_busy = 0;
      wr_log.delete(); tx_log.delete();
   endtask

   task automatic wait_state(input logic [2:0] s, input int max_cyc, input string name);
      int n = 0;
      @(negedge i_Clk);
      while (o_state !== s && n < max_cyc) begin
         @(negedge i_Clk);
         n++;
      end
      check(name, o_state, s);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_state"}, o_state, 3'd0);
      check({tag, "_error"}, o_error, 1'b0);
      check({tag, "_tx_data"}, o_tx_data, 8'h00);
      check({tag, "_send"}, o_send_to_computer, 1'b0);
      check({tag, "_mem_index"}, o_mem_index, 4'd0);
      check({tag, "_rx_number"}, o_rx_number, 32'd0);
      check({tag, "_mem_we"}, o_mem_we, 1'b0);
      check({tag, "_proc_start"}, o_proc_start, 1'b0);
   endtask

   task automatic check_end(input string tag, input int starts, input int sent, input int busy, input logic err);
      check({tag, "_writes_left"}, exp_wr.size(), 0);
      check({tag, "_bytes_left"}, exp_tx.size(), 0);
      check({tag, "_starts"}, n_starts, starts);
      check({tag, "_sent"}, n_sent, sent);
      check({tag, "_busy_pulses"}, n_busy, busy);
      check({tag, "_error"}, o_error, err);
      check({tag, "_state"}, o_state, 3'd0);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < 16; i++) res_mem[i] = '0;
      i_Rst = 1'b1; i_rx_data = '0; i_rx_end = 1'b0;
      repeat (3) @(negedge i_Clk);
      check_outputs_zero("reset");
      i_Rst = 1'b0;

      // Noise, sync, four words of 78 56 34 12; result DEADBEEF.
      clear_logs();
      for (int i = 0; i < N_IN; i++) frame_words[i] = 32'h12345678;
      expect_frame(32'hDEADBEEF, 1'b1);
      send_byte(8'h00);
      send_byte(8'hFF);
      check("noise_ignored", o_state, 3'd0);
      send_byte(8'hA5);
      repeat (N_IN) begin
         send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
      end
      wait_state(3'd0, 500, "f1_idle");
      check_end("f1", 1, 4, 4, 1'b0);
      check("f1_nwr", wr_log.size(), 4);
      if (wr_log.size() == 4) begin
         check("f1_wr0", wr_log[0], {4'd0, 32'h12345678});
         check("f1_wr3", wr_log[3], {4'd3, 32'h12345678});
      end
      check("f1_ntx", tx_log.size(), 4);
      if (tx_log.size() == 4)
         check("f1_txlog", {tx_log[0], tx_log[1], tx_log[2], tx_log[3]}, 32'hEFBEADDE);

      // Silent transmitter, stray bytes while processor runs.
      clear_logs();
      uart_silent = 1'b1;
      frame_words[0] = 32'h11223344; frame_words[1] = 32'h55667788;
      frame_words[2] = 32'h99AABBCC; frame_words[3] = 32'hDDEEFF00;
      expect_frame(32'h0BADF00D, 1'b1);
      send_frame(1'b1);
      n = 0;
      while (!i_proc_busy && n < 50) begin @(negedge i_Clk); n++; end
      check("f2_busy_seen", i_proc_busy, 1'b1);
      send_byte(8'hA5);
      send_byte(8'h5A);
      check("f2_stray_state", o_state, 3'd4);
      wait_state(3'd0, 500, "f2_idle");
      check_end("f2", 1, 4, 0, 1'b0);
      check("f2_nwr", wr_log.size(), 4);
      if (tx_log.size() == 4)
         check("f2_txlog", {tx_log[0], tx_log[1], tx_log[2], tx_log[3]}, 32'h0DF0AD0B);
      uart_silent = 1'b0;

      // Gap timeout after two bytes of a word.
      clear_logs();
      send_byte(8'hA5);
      send_byte(8'h11);
      send_byte(8'h22);
      repeat (90) @(negedge i_Clk);
      check("gap_still_rx", o_state, 3'd1);
      wait_state(3'd0, 30, "gap_idle");
      check_end("gap", 0, 0, 0, 1'b1);
      check("gap_nwr", wr_log.size(), 0);

      // Sync clears error; processor never goes busy.
      clear_logs();
      proc_mode = 1'b0;
      send_byte(8'hA5);
      check("sync_clears_error", o_error, 1'b0);
      frame_words[0] = 32'hA5A5A5A5; frame_words[1] = 32'h00000001;
      frame_words[2] = 32'h80000000; frame_words[3] = 32'hFFFFFFFF;
      expect_frame(32'h13572468, 1'b0);
      send_frame(1'b0);
      wait_state(3'd3, 20, "ptmo_wait_rise");
      n = 0;
      while (o_state == 3'd3 && n < 1000) begin n++; @(negedge i_Clk); end
      check("ptmo_cycles", n, PROC_T);
      check_end("ptmo", 1, 0, 0, 1'b1);
      proc_mode = 1'b1;

      // Reset during the second transmitted byte, then a clean frame.
      clear_logs();
      frame_words[0] = 32'hCAFE0001; frame_words[1] = 32'hCAFE0002;
      frame_words[2] = 32'hCAFE0003; frame_words[3] = 32'hCAFE0004;
      expect_frame(32'h87654321, 1'b1);
      send_frame(1'b1);
      n = 0;
      while (n_sent < 2 && n < 500) begin @(negedge i_Clk); n++; end
      check("rst_sent_before", n_sent, 2);
      @(posedge i_Clk);
      #2 i_Rst = 1'b1;
      tx_track = 1'b0;
      #1 check_outputs_zero("midtx_reset");
      exp_tx.delete();
      exp_wr.delete();
      repeat (2) @(negedge i_Clk);
      i_Rst = 1'b0;
      clear_logs();
      repeat (20) @(negedge i_Clk);
      check("no_retransmit", n_sent, 0);
      frame_words[0] = 32'h0F1E2D3C; frame_words[1] = 32'h4B5A6978;
      frame_words[2] = 32'h8796A5B4; frame_words[3] = 32'hC3D2E1F0;
      expect_frame(32'h00A55A00, 1'b1);
      send_frame(1'b1);
      wait_state(3'd0, 500, "f5_idle");
      check_end("f5", 1, 4, 4, 1'b0);
      if (tx_log.size() == 4)
         check("f5_txlog", {tx_log[0], tx_log[1], tx_log[2], tx_log[3]}, 32'h005AA500);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
